// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates NUM_CH requesters onto a byte-wide synchronous memory port.
module mem_port_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic [NUM_CH-1:0]    req_in,
    input  logic [NUM_CH-1:0]    wr_in,
    input  logic [NUM_CH*32-1:0] addr_in,
    input  logic [NUM_CH*2-1:0]  len_in,
    input  logic [NUM_CH*32-1:0] wdata_in,
    output logic [NUM_CH-1:0]    done_out,
    output logic [31:0]          rdata_out,
    output logic                 busy_out,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [31:0]          mem_a,
    output logic                 mem_wr
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state, state_n;
    logic [3:0] req_x, wr_x;
    logic [3:0][1:0] len_x;
    logic [3:0][31:0] addr_x, wdata_x;
    logic [1:0] ptr, ptr_n, sel, len_q, len_n;
    logic [2:0] cnt, cnt_n, last, last_n;
    logic [31:0] addr_q, addr_n, wdata_q, wdata_n, rbuf, rbuf_n, rdata_n, mem_a_n;
    logic [7:0] mem_dout_n;
    logic [NUM_CH-1:0] done_q, done_n;
    logic mem_wr_q, mem_wr_n, busy_n, grant;

    // Channels padded to four so a 2-bit index is always in range.
    assign req_x   = 4'(req_in);
    assign wr_x    = 4'(wr_in);
    assign len_x   = 8'(len_in);
    assign addr_x  = 128'(addr_in);
    assign wdata_x = 128'(wdata_in);

    function automatic logic [1:0] cand(input int i, input logic [1:0] p);
        return (PRIO_MODE != 0) ? 2'(i) : 2'((int'(p) + 1 + i) % NUM_CH);
    endfunction

    function automatic logic [2:0] last_of(input logic [1:0] len);
        return len[1] ? 3'd3 : {2'b00, len[0]};
    endfunction

    // Scan from lowest to highest priority so the highest-priority requester wins.
    always_comb begin
        sel = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (req_x[cand(i, ptr)]) sel = cand(i, ptr);
    end

    assign grant  = (state == IDLE) && |req_in;
    assign last   = last_of(len_q);
    assign last_n = last_of(len_n);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state <= IDLE;
        else if (rdy_in)
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = grant ? (wr_x[sel] ? WRITE : READ) : IDLE;
            READ:  state_n = (cnt == last + 3'd1) ? DONE : READ;
            WRITE: state_n = (cnt == last) ? DONE : WRITE;
            DONE:  state_n = IDLE;
        endcase
    end

    // Read byte k arrives one cycle after its address, so capture lags the counter by one.
    always_comb begin
        ptr_n      = grant ? sel : ptr;
        addr_n     = grant ? addr_x[sel] : addr_q;
        len_n      = grant ? len_x[sel] : len_q;
        wdata_n    = grant ? wdata_x[sel] : wdata_q;
        cnt_n      = (state == READ || state == WRITE) ? cnt + 3'd1 : 3'd0;
        rbuf_n     = (state != READ) ? 32'd0 : (cnt == 3'd0) ? rbuf : rbuf | (32'(mem_din) << {cnt - 3'd1, 3'b000});
        rdata_n    = (state == READ && state_n == DONE) ? rbuf_n : rdata_out;
        mem_wr_n   = state_n == WRITE;
        mem_a_n    = (state_n == WRITE || (state_n == READ && cnt_n <= last_n)) ? addr_n + 32'(cnt_n) : 32'd0;
        mem_dout_n = (state_n == WRITE) ? 8'(wdata_n >> {cnt_n[1:0], 3'b000}) : 8'd0;
        busy_n     = state_n != IDLE;
        for (int i = 0; i < NUM_CH; i++)
            done_n[i] = (state_n == DONE) && (ptr_n == 2'(i));
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ptr       <= 2'(NUM_CH - 1);
            addr_q    <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            rbuf      <= '0;
            rdata_out <= '0;
            mem_wr_q  <= 1'b0;
            mem_a     <= '0;
            mem_dout  <= '0;
            busy_out  <= 1'b0;
            done_q    <= '0;
        end else if (rdy_in) begin
            ptr       <= ptr_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            wdata_q   <= wdata_n;
            cnt       <= cnt_n;
            rbuf      <= rbuf_n;
            rdata_out <= rdata_n;
            mem_wr_q  <= mem_wr_n;
            mem_a     <= mem_a_n;
            mem_dout  <= mem_dout_n;
            busy_out  <= busy_n;
            done_q    <= done_n;
        end
    end

    // A stall masks strobes without losing them; they reappear once rdy_in returns.
    assign mem_wr   = mem_wr_q & rdy_in;
    assign done_out = done_q & {NUM_CH{rdy_in}};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of reads, writes, stalls, reset and arbitration order.
module tb_mem_port_arbiter;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in;
    logic [1:0] req_in, wr_in, done_out, done_p;
    logic [3:0] len_in;
    logic [63:0] addr_in, wdata_in;
    logic [31:0] rdata_out, mem_a, rdata_p, a_p;
    logic [7:0] mem_din, mem_dout, dout_p;
    logic busy_out, mem_wr, busy_p, wr_p;
    int checks = 0;
    int errors = 0;
    int nwr = 0;
    logic [31:0] wlog_a [16];
    logic [7:0] wlog_d [16];
    logic [1:0] rr_seq [4];
    logic [1:0] pr_seq [4];
    int n_rr, n_pr, pulses, w0;

    mem_port_arbiter #(.NUM_CH(2), .PRIO_MODE(0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_in(req_in), .wr_in(wr_in),
        .addr_in(addr_in), .len_in(len_in), .wdata_in(wdata_in), .done_out(done_out),
        .rdata_out(rdata_out), .busy_out(busy_out), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
    );

    mem_port_arbiter #(.NUM_CH(2), .PRIO_MODE(1)) dut_p (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_in(req_in), .wr_in(wr_in),
        .addr_in(addr_in), .len_in(len_in), .wdata_in(wdata_in), .done_out(done_p),
        .rdata_out(rdata_p), .busy_out(busy_p), .mem_din(mem_din), .mem_dout(dout_p),
        .mem_a(a_p), .mem_wr(wr_p)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            32'h200: return 8'h5A;
            32'h201: return 8'h6B;
            32'h202: return 8'h7C;
            32'h203: return 8'h8D;
            32'hFFFFFFFF: return 8'hC3;
            default: return 8'h00;
        endcase
    endfunction

    // Synchronous memory: one-cycle read latency, paused together with the arbiter.
    always @(posedge clk_in) begin
        if (rdy_in) mem_din <= rom(mem_a);
        if (mem_wr && nwr < 16) begin
            wlog_a[nwr] <= mem_a;
            wlog_d[nwr] <= mem_dout;
            nwr <= nwr + 1;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; req_in = '0; wr_in = '0; addr_in = '0; len_in = '0; wdata_in = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_done", 32'(done_out), 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_mem_dout", 32'(mem_dout), 0);
        chk("rst_rdata", rdata_out, 0);
        rst_in = 1'b1;
        tick();
        // ch0 four-byte read at 0x100
        req_in = 2'b01; wr_in = 2'b00; addr_in[31:0] = 32'h100; len_in[1:0] = 2'b10;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("rd4_mem_a", mem_a, 32'h100 + 32'(k));
            chk("rd4_mem_wr", 32'(mem_wr), 0);
            chk("rd4_busy", 32'(busy_out), 1);
            tick();
        end
        chk("rd4_last_mem_a", mem_a, 0);
        chk("rd4_early_done", 32'(done_out), 0);
        tick();
        chk("rd4_done", 32'(done_out), 32'h1);
        chk("rd4_rdata", rdata_out, 32'h44332211);
        chk("rd4_done_busy", 32'(busy_out), 1);
        req_in = 2'b00;
        tick();
        chk("rd4_idle_busy", 32'(busy_out), 0);
        chk("rd4_idle_done", 32'(done_out), 0);
        chk("rd4_hold_rdata", rdata_out, 32'h44332211);
        // ch1 two-byte write to the I/O region
        req_in = 2'b10; wr_in = 2'b10; addr_in[63:32] = 32'h30000; len_in[3:2] = 2'b01; wdata_in[63:32] = 32'hAABB;
        w0 = nwr;
        tick();
        chk("wr2_b0_wr", 32'(mem_wr), 1);
        chk("wr2_b0_a", mem_a, 32'h30000);
        chk("wr2_b0_d", 32'(mem_dout), 32'hBB);
        tick();
        chk("wr2_b1_wr", 32'(mem_wr), 1);
        chk("wr2_b1_a", mem_a, 32'h30001);
        chk("wr2_b1_d", 32'(mem_dout), 32'hAA);
        tick();
        chk("wr2_done", 32'(done_out), 32'h2);
        chk("wr2_done_wr", 32'(mem_wr), 0);
        chk("wr2_done_a", mem_a, 0);
        chk("wr2_done_d", 32'(mem_dout), 0);
        chk("wr2_rdata_kept", rdata_out, 32'h44332211);
        req_in = 2'b00;
        tick();
        chk("wr2_count", 32'(nwr - w0), 2);
        chk("wr2_log0", {wlog_d[w0], wlog_a[w0][23:0]}, 32'hBB030000);
        chk("wr2_log1", {wlog_d[w0 + 1], wlog_a[w0 + 1][23:0]}, 32'hAA030001);
        // ch0 four-byte read at 0x200 with a 3-cycle stall and inputs changing mid-flight
        req_in = 2'b01; wr_in = 2'b00; addr_in[31:0] = 32'h200; len_in[1:0] = 2'b10;
        tick();
        chk("stl_a0", mem_a, 32'h200);
        addr_in[31:0] = 32'hDEAD0000; len_in[1:0] = 2'b00;
        tick();
        chk("stl_a1", mem_a, 32'h201);
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stl_frozen_a", mem_a, 32'h201);
            chk("stl_frozen_wr", 32'(mem_wr), 0);
            chk("stl_frozen_done", 32'(done_out), 0);
        end
        rdy_in = 1'b1;
        tick();
        chk("stl_a2", mem_a, 32'h202);
        chk("stl_no_done", 32'(done_out), 0);
        tick();
        chk("stl_a3", mem_a, 32'h203);
        tick();
        chk("stl_pre_done", 32'(done_out), 0);
        tick();
        chk("stl_done", 32'(done_out), 32'h1);
        chk("stl_rdata", rdata_out, 32'h8D7C6B5A);
        req_in = 2'b00;
        tick();
        // single-byte read at the top of the address space
        req_in = 2'b01; addr_in[31:0] = 32'hFFFFFFFF; len_in[1:0] = 2'b00;
        tick();
        chk("b1_a0", mem_a, 32'hFFFFFFFF);
        tick();
        chk("b1_tail_a", mem_a, 0);
        chk("b1_tail_done", 32'(done_out), 0);
        tick();
        chk("b1_done", 32'(done_out), 32'h1);
        chk("b1_rdata", rdata_out, 32'h000000C3);
        req_in = 2'b00;
        tick();
        // reset in the middle of a four-byte write
        req_in = 2'b10; wr_in = 2'b10; addr_in[63:32] = 32'h40000; len_in[3:2] = 2'b10; wdata_in[63:32] = 32'h01020304;
        w0 = nwr;
        tick();
        chk("rw_b0_d", 32'(mem_dout), 32'h04);
        tick();
        chk("rw_b1_wr", 32'(mem_wr), 1);
        chk("rw_b1_a", mem_a, 32'h40001);
        rst_in = 1'b0;
        #1;
        chk("rw_rst_wr", 32'(mem_wr), 0);
        chk("rw_rst_busy", 32'(busy_out), 0);
        chk("rw_rst_a", mem_a, 0);
        chk("rw_rst_d", 32'(mem_dout), 0);
        chk("rw_rst_rdata", rdata_out, 0);
        req_in = 2'b00;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done_out != 2'b00 || done_p != 2'b00) pulses++;
        end
        chk("rw_no_done", 32'(pulses), 0);
        chk("rw_writes", 32'(nwr - w0), 1);
        // both channels request continuously; no grant while paused out of reset
        rst_in = 1'b1; rdy_in = 1'b0;
        req_in = 2'b11; wr_in = 2'b11; len_in = 4'b0000;
        addr_in = {32'h600, 32'h500}; wdata_in = {32'h22, 32'h11};
        tick();
        chk("arb_paused_busy", 32'(busy_out), 0);
        rdy_in = 1'b1;
        n_rr = 0; n_pr = 0; w0 = nwr;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (done_out != 2'b00 && n_rr < 4) begin rr_seq[n_rr] = done_out; n_rr++; end
            if (done_p != 2'b00 && n_pr < 4) begin pr_seq[n_pr] = done_p; n_pr++; end
        end
        chk("rr_count", 32'(n_rr), 3);
        chk("rr_g0", 32'(rr_seq[0]), 32'h1);
        chk("rr_g1", 32'(rr_seq[1]), 32'h2);
        chk("rr_g2", 32'(rr_seq[2]), 32'h1);
        chk("pr_count", 32'(n_pr), 3);
        chk("pr_g0", 32'(pr_seq[0]), 32'h1);
        chk("pr_g1", 32'(pr_seq[1]), 32'h1);
        chk("pr_g2", 32'(pr_seq[2]), 32'h1);
        chk("rr_wr0", {wlog_d[w0], wlog_a[w0][23:0]}, 32'h11000500);
        chk("rr_wr1", {wlog_d[w0 + 1], wlog_a[w0 + 1][23:0]}, 32'h22000600);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
